// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier producing the low N bits of op_a*op_b by borrowing the shared ALU.
// Each granted RUN cycle performs one accumulate step; DONE pulses for a single cycle.
module alu_mul_sequencer #(
  parameter int unsigned N       = 32,
  parameter logic [3:0]  SEL_ADD = 4'h0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_flush,
  input  logic [N-1:0] i_op_a,
  input  logic [N-1:0] i_op_b,
  output logic         o_ready,
  output logic         o_done,
  output logic [N-1:0] o_product,
  output logic         o_alu_req,
  input  logic         i_alu_gnt,
  output logic [N-1:0] o_alu_a,
  output logic [N-1:0] o_alu_b,
  output logic [3:0]   o_alu_sel,
  input  logic [N-1:0] i_alu_result
);

  localparam int unsigned CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state,   w_state_d;
  logic [N-1:0]     r_acc,     w_acc_d;
  logic [N-1:0]     r_mcand,   w_mcand_d;
  logic [N-1:0]     r_mplier,  w_mplier_d;
  logic [CNT_W-1:0] r_cnt,     w_cnt_d;
  logic [N-1:0]     r_product, w_product_d;
  logic             w_run;

  assign w_run = (r_state == ST_RUN);

  always_comb begin
    w_state_d   = r_state;
    w_acc_d     = r_acc;
    w_mcand_d   = r_mcand;
    w_mplier_d  = r_mplier;
    w_cnt_d     = r_cnt;
    w_product_d = r_product;
    case (r_state)
      ST_IDLE: begin
        // flush beats start so an abort in the same cycle never launches a multiply
        if (i_start && !i_flush) begin
          w_acc_d    = '0;
          w_mcand_d  = i_op_a;
          w_mplier_d = i_op_b;
          w_cnt_d    = '0;
          w_state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_flush) begin
          w_state_d = ST_IDLE;
        end else if (i_alu_gnt) begin
          w_acc_d    = i_alu_result;
          w_mcand_d  = r_mcand << 1;
          w_mplier_d = r_mplier >> 1;
          w_cnt_d    = r_cnt + 1'b1;
          if (r_cnt == CNT_MAX) begin
            w_product_d = i_alu_result;
            w_state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state   <= w_state_d;
      r_acc     <= w_acc_d;
      r_mcand   <= w_mcand_d;
      r_mplier  <= w_mplier_d;
      r_cnt     <= w_cnt_d;
      r_product <= w_product_d;
    end
  end

  assign o_ready   = (r_state == ST_IDLE);
  assign o_done    = (r_state == ST_DONE);
  assign o_alu_req = w_run;
  assign o_alu_sel = SEL_ADD;
  assign o_alu_a   = w_run ? r_acc : '0;
  assign o_alu_b   = (w_run && r_mplier[0]) ? r_mcand : '0;
  assign o_product = r_product;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench: table vectors, random operands/grants against a*b, and
// hand-written flush / reset / ignored-start sequences.
module tb_alu_mul_sequencer;
  localparam int unsigned N = 32;
  localparam logic [3:0] SEL = 4'h0;

  logic         clk, rst_n, start, flush, gnt;
  logic [N-1:0] op_a, op_b, product, alu_a, alu_b, alu_result;
  logic         ready, done, alu_req;
  logic [3:0]   alu_sel;

  int checks = 0;
  int errors = 0;

  alu_mul_sequencer #(.N(N), .SEL_ADD(SEL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_flush(flush),
    .i_op_a(op_a), .i_op_b(op_b), .o_ready(ready), .o_done(done),
    .o_product(product), .o_alu_req(alu_req), .i_alu_gnt(gnt),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel),
    .i_alu_result(alu_result)
  );

  // The shared ALU: plain adder
  assign alu_result = alu_a + alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Launch a multiply from IDLE and wait for done; reports product, latency in
  // edges after the accept edge, and the number of ungranted RUN cycles.
  task automatic run_mul(input logic [N-1:0] a, input logic [N-1:0] b, input int gnt_pct,
                         output logic [N-1:0] prod, output int lat, output int stalls);
    logic [N-1:0] sa, sb;
    bit stalled;
    bit seen;
    lat = 0; stalls = 0; stalled = 0; seen = 0; prod = '0;
    @(negedge clk);
    check("ready_before_start", {31'b0, ready}, 32'd1);
    op_a = a; op_b = b; start = 1'b1; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (lat < 400) begin
      if (stalled && alu_req) begin
        check("stall_alu_a", alu_a, sa);
        check("stall_alu_b", alu_b, sb);
      end
      stalled = 0;
      if (done) begin
        seen = 1;
        break;
      end
      gnt = ($urandom_range(99) < gnt_pct);
      if (alu_req && !gnt) begin
        stalls++;
        stalled = 1;
        sa = alu_a; sb = alu_b;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!seen) begin
      errors++; checks++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", lat);
    end
    prod = product;
    gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("ready_after_done", {31'b0, ready}, 32'd1);
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           gnt_pct;
    logic [N-1:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [N-1:0] p, ra, rb;
    int lat, st, dcnt;

    vecs[0] = '{32'd7,        32'd6,        100, 32'd42};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 100, 32'h00000001};
    vecs[2] = '{32'hFFFFFFFD, 32'h00000005, 100, 32'hFFFFFFF1};
    vecs[3] = '{32'h00010000, 32'h00010000, 100, 32'h00000000};
    vecs[4] = '{32'd12345,    32'd6789,     50,  32'd83810205};
    vecs[5] = '{32'h1234ABCD, 32'd0,        70,  32'd0};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; gnt = 1'b1; op_a = '0; op_b = '0;
    #12;
    check("rst_ready",   {31'b0, ready},   32'd1);
    check("rst_done",    {31'b0, done},    32'd0);
    check("rst_product", product,          32'd0);
    check("rst_alu_req", {31'b0, alu_req}, 32'd0);
    check("rst_alu_a",   alu_a,            32'd0);
    check("rst_alu_b",   alu_b,            32'd0);
    check("rst_alu_sel", {28'b0, alu_sel}, {28'b0, SEL});
    @(negedge clk);
    rst_n = 1'b1;

    // start with flush in IDLE: no accept
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_ready", {31'b0, ready},   32'd1);
    check("start_flush_req",   {31'b0, alu_req}, 32'd0);

    foreach (vecs[i]) begin
      run_mul(vecs[i].a, vecs[i].b, vecs[i].gnt_pct, p, lat, st);
      check($sformatf("vec%0d_product", i), p, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, N + st);
    end

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 4 == 0) rb = rb & 32'h0000000F;
      run_mul(ra, rb, $urandom_range(100, 30), p, lat, st);
      check($sformatf("rand%0d_product", i), p, ra * rb);
      check($sformatf("rand%0d_latency", i), lat, N + st);
    end

    // Flush in the 10th RUN cycle keeps the prior product (42)
    run_mul(32'd7, 32'd6, 100, p, lat, st);
    check("pre_flush_product", p, 32'd42);
    @(negedge clk);
    op_a = 32'd9; op_b = 32'd9; start = 1'b1; gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready",   {31'b0, ready}, 32'd1);
    check("flush_done",    {31'b0, done},  32'd0);
    check("flush_product", product,        32'd42);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("flush_no_done", dcnt, 32'd0);
    run_mul(32'd3, 32'd4, 100, p, lat, st);
    check("post_flush_product", p, 32'd12);

    // Async reset in RUN cycle 5
    @(negedge clk);
    op_a = 32'd5; op_b = 32'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_req", {31'b0, alu_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ready",   {31'b0, ready}, 32'd1);
    check("midrst_product", product,        32'd0);
    check("midrst_done",    {31'b0, done},  32'd0);
    dcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst_no_done", dcnt, 32'd0);

    // start held through RUN and DONE must not queue a second multiply
    @(negedge clk);
    op_a = 32'd3; op_b = 32'd3; start = 1'b1; gnt = 1'b1;
    @(posedge clk);
    dcnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        op_a = 32'd11;
      end else if (ready) begin
        start = 1'b0;
      end
    end
    check("busy_start_dones",   dcnt,    32'd1);
    check("busy_start_product", product, 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
